// File: rtl/pulse_generator_pkg.sv
// Shared constants and types for the pulse generator and its loopback monitor.
package pulse_generator_pkg;

    localparam int unsigned start_delay_c     = 3;
    localparam int unsigned pulse_width_c     = 4;
    localparam int unsigned reset_delay_c     = 2;
    localparam int unsigned pulse_mon_cnt_w_c = 8;

    typedef enum logic [1:0] {
        MON_IDLE         = 2'd0,
        MON_WAIT_RISE    = 2'd1,
        MON_MEASURE_HIGH = 2'd2
    } pulse_mon_state_t;

endpackage

// File: rtl/pulse_sync_2ff.sv
// Generic 1-bit two-flop synchronizer with synchronous active-high clear.
module pulse_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pulse_monitor.sv
// Receive-side checker: measures start-to-rise delay and high width of a returned pulse.
// Optional PULSE_MONITOR_SYNC_EN: 2-flop synchronizer on pulse_in and matching 2-stage start delay.
module pulse_monitor
    import pulse_generator_pkg::*;
#(
    parameter int unsigned CNT_W     = pulse_mon_cnt_w_c,
    parameter int unsigned TIMEOUT_C = 200,
    parameter int unsigned EXP_DELAY = start_delay_c,
    parameter int unsigned EXP_WIDTH = pulse_width_c
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pulse_in,
    output logic             busy,
    output logic             result_valid,
    output logic [CNT_W-1:0] meas_delay,
    output logic [CNT_W-1:0] meas_width,
    output logic             match,
    output logic             timeout_err,
    output logic             width_ovf,
    output logic             spurious_err
);

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_C);
    localparam logic [CNT_W-1:0] EXP_D_CNT   = CNT_W'(EXP_DELAY);
    localparam logic [CNT_W-1:0] EXP_W_CNT   = CNT_W'(EXP_WIDTH);

    pulse_mon_state_t r_state;
    pulse_mon_state_t w_state_nxt;

    logic             w_pulse;
    logic             w_start;
    logic             w_rise;
    logic             r_pulse_prev;

    logic [CNT_W-1:0] r_delay_cnt;
    logic [CNT_W-1:0] r_delay_q;
    logic [CNT_W-1:0] r_width_cnt;
    logic [CNT_W-1:0] w_delay_cnt_nxt;
    logic [CNT_W-1:0] w_delay_q_nxt;
    logic [CNT_W-1:0] w_width_cnt_nxt;

    logic             w_report;
    logic [CNT_W-1:0] w_rep_delay;
    logic [CNT_W-1:0] w_rep_width;
    logic             w_rep_timeout;
    logic             w_rep_ovf;
    logic             w_rep_match;
    logic             w_spurious;

    logic             r_busy;
    logic             r_result_valid;
    logic [CNT_W-1:0] r_meas_delay;
    logic [CNT_W-1:0] r_meas_width;
    logic             r_match;
    logic             r_timeout_err;
    logic             r_width_ovf;
    logic             r_spurious_err;

`ifdef PULSE_MONITOR_SYNC_EN
    // Start goes through the same two flops so delay measurement is unaffected.
    pulse_sync_2ff u_pulse_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (pulse_in),
        .o_q   (w_pulse)
    );

    pulse_sync_2ff u_start_dly (
        .clk   (clk),
        .reset (reset),
        .i_d   (start),
        .o_q   (w_start)
    );
`else
    assign w_pulse = pulse_in;
    assign w_start = start;
`endif

    assign w_rise = w_pulse & ~r_pulse_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MON_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MON_IDLE: begin
                if (w_start) begin
                    w_state_nxt = MON_WAIT_RISE;
                end
            end
            MON_WAIT_RISE: begin
                if (w_rise) begin
                    w_state_nxt = MON_MEASURE_HIGH;
                end else if (r_delay_cnt == TIMEOUT_CNT) begin
                    w_state_nxt = MON_IDLE;
                end
            end
            MON_MEASURE_HIGH: begin
                if (!w_pulse) begin
                    w_state_nxt = w_start ? MON_WAIT_RISE : MON_IDLE;
                end
            end
            default: w_state_nxt = MON_IDLE;
        endcase
    end

    // Counter updates and report contents for the current cycle.
    always_comb begin
        w_delay_cnt_nxt = r_delay_cnt;
        w_delay_q_nxt   = r_delay_q;
        w_width_cnt_nxt = r_width_cnt;
        w_report        = 1'b0;
        w_rep_delay     = r_delay_q;
        w_rep_width     = r_width_cnt;
        w_rep_timeout   = 1'b0;
        w_rep_ovf       = 1'b0;
        w_spurious      = 1'b0;
        case (r_state)
            MON_IDLE: begin
                w_spurious = w_rise;
                if (w_start) begin
                    w_delay_cnt_nxt = CNT_ONE;
                end
            end
            MON_WAIT_RISE: begin
                if (w_rise) begin
                    w_delay_q_nxt   = r_delay_cnt;
                    w_width_cnt_nxt = CNT_ONE;
                end else if (r_delay_cnt == TIMEOUT_CNT) begin
                    w_report      = 1'b1;
                    w_rep_delay   = TIMEOUT_CNT;
                    w_rep_width   = '0;
                    w_rep_timeout = 1'b1;
                end else begin
                    w_delay_cnt_nxt = r_delay_cnt + CNT_ONE;
                end
            end
            MON_MEASURE_HIGH: begin
                if (w_pulse) begin
                    if (r_width_cnt != CNT_MAX) begin
                        w_width_cnt_nxt = r_width_cnt + CNT_ONE;
                    end
                end else begin
                    w_report  = 1'b1;
                    w_rep_ovf = (r_width_cnt == CNT_MAX);
                    if (w_start) begin
                        w_delay_cnt_nxt = CNT_ONE;
                    end
                end
            end
            default: ;
        endcase
        w_rep_match = (w_rep_delay == EXP_D_CNT) && (w_rep_width == EXP_W_CNT)
                      && !w_rep_timeout && !w_rep_ovf;
    end

    // Result fields hold until the next report; strobes last one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pulse_prev   <= 1'b0;
            r_delay_cnt    <= '0;
            r_delay_q      <= '0;
            r_width_cnt    <= '0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_meas_delay   <= '0;
            r_meas_width   <= '0;
            r_match        <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_width_ovf    <= 1'b0;
            r_spurious_err <= 1'b0;
        end else begin
            r_pulse_prev   <= w_pulse;
            r_delay_cnt    <= w_delay_cnt_nxt;
            r_delay_q      <= w_delay_q_nxt;
            r_width_cnt    <= w_width_cnt_nxt;
            r_busy         <= (w_state_nxt != MON_IDLE);
            r_result_valid <= w_report;
            r_spurious_err <= w_spurious;
            if (w_report) begin
                r_meas_delay  <= w_rep_delay;
                r_meas_width  <= w_rep_width;
                r_match       <= w_rep_match;
                r_timeout_err <= w_rep_timeout;
                r_width_ovf   <= w_rep_ovf;
            end
        end
    end

    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign meas_delay   = r_meas_delay;
    assign meas_width   = r_meas_width;
    assign match        = r_match;
    assign timeout_err  = r_timeout_err;
    assign width_ovf    = r_width_ovf;
    assign spurious_err = r_spurious_err;

endmodule
